// File: rtl/if_id_skid_pkg.sv
// Shared types and constants for the IF/ID elastic skid buffer.
package if_id_skid_pkg;

    // Default number of independent hardware threads.
    localparam int NUM_Threads = 4;

    // Canonical NOP (addi x0, x0, 0) presented when a slot holds no beat.
    localparam logic [31:0] NOP_INSN_WORD = 32'h0000_0013;

    // Occupancy of one thread's two-entry buffer (main + skid).
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_ONE   = 2'd1,
        SLOT_TWO   = 2'd2
    } slot_state_e;

endpackage

// File: rtl/if_id_slot.sv
// Single-thread IF/ID elastic buffer: main entry plus skid entry and a
// saturating back-pressure counter. in_ready depends only on registered
// state, so there is no combinational path from out_ready to in_ready.
module if_id_slot
    import if_id_skid_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INSN = XLEN'(NOP_INSN_WORD),
    parameter int              CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_insn_addr,
    input  logic [XLEN-1:0]  in_insn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_insn_addr,
    output logic [XLEN-1:0]  out_insn,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int BW = 3 * XLEN;

    slot_state_e      state_q, state_d;
    logic [BW-1:0]    main_q, main_d;
    logic [BW-1:0]    skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0]    in_beat;
    logic             push;
    logic             pop;

    // Beat layout: {pc, insn_addr, insn}
    assign in_beat   = {in_pc, in_insn_addr, in_insn};
    assign in_ready  = (state_q != SLOT_TWO);
    assign out_valid = (state_q != SLOT_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state and payload steering; flush overrides every transition and
    // leaves the payload registers untouched (outputs are masked when empty).
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            SLOT_EMPTY: begin
                if (push) begin
                    state_d = SLOT_ONE;
                    main_d  = in_beat;
                end
            end
            SLOT_ONE: begin
                if (push && pop) begin
                    main_d = in_beat;
                end else if (push) begin
                    state_d = SLOT_TWO;
                    skid_d  = in_beat;
                end else if (pop) begin
                    state_d = SLOT_EMPTY;
                end
            end
            SLOT_TWO: begin
                if (pop) begin
                    state_d = SLOT_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
        if (flush) begin
            state_d = SLOT_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    // Count consecutive cycles a beat waits on out_ready, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (flush || pop) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, payload and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SLOT_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_pc        = out_valid ? main_q[3*XLEN-1:2*XLEN] : '0;
    assign out_insn_addr = out_valid ? main_q[2*XLEN-1:XLEN]   : '0;
    assign out_insn      = out_valid ? main_q[XLEN-1:0]        : NOP_INSN;
    assign stall_cnt     = cnt_q;

endmodule

// File: rtl/if_id_skid.sv
// Multi-thread IF/ID pipeline register: one independent elastic slot per
// hardware thread, no interaction between threads.
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int              NUM_THREADS = NUM_Threads,
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] NOP_INSN    = XLEN'(NOP_INSN_WORD),
    parameter int              CNT_W       = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_THREADS-1:0]              in_valid,
    output logic [NUM_THREADS-1:0]              in_ready,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]    in_pc,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]    in_insn_addr,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]    in_insn,
    output logic [NUM_THREADS-1:0]              out_valid,
    input  logic [NUM_THREADS-1:0]              out_ready,
    output logic [NUM_THREADS-1:0][XLEN-1:0]    out_pc,
    output logic [NUM_THREADS-1:0][XLEN-1:0]    out_insn_addr,
    output logic [NUM_THREADS-1:0][XLEN-1:0]    out_insn,
    input  logic [NUM_THREADS-1:0]              flush,
    output logic [NUM_THREADS-1:0][CNT_W-1:0]   stall_cnt
);

    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_slot
        if_id_slot #(
            .XLEN     (XLEN),
            .NOP_INSN (NOP_INSN),
            .CNT_W    (CNT_W)
        ) u_slot (
            .clk           (clk),
            .rst           (rst),
            .in_valid      (in_valid[g]),
            .in_ready      (in_ready[g]),
            .in_pc         (in_pc[g]),
            .in_insn_addr  (in_insn_addr[g]),
            .in_insn       (in_insn[g]),
            .out_valid     (out_valid[g]),
            .out_ready     (out_ready[g]),
            .out_pc        (out_pc[g]),
            .out_insn_addr (out_insn_addr[g]),
            .out_insn      (out_insn[g]),
            .flush         (flush[g]),
            .stall_cnt     (stall_cnt[g])
        );
    end

endmodule
